// File: rtl/procesador_pkg.sv
// Shared encodings for the procesador datapath: ALU and shifter function codes,
// plus the bit positions of the ALU status flags in Tags.
package procesador_pkg;

    typedef enum logic [3:0] {
        G_PASS  = 4'b0000,
        G_INC   = 4'b0001,
        G_ADD   = 4'b0010,
        G_ADDC  = 4'b0011,
        G_ADDNB = 4'b0100,
        G_SUB   = 4'b0101,
        G_DEC   = 4'b0110,
        G_PASS2 = 4'b0111,
        G_AND   = 4'b1000,
        G_AND2  = 4'b1001,
        G_OR    = 4'b1010,
        G_OR2   = 4'b1011,
        G_XOR   = 4'b1100,
        G_XOR2  = 4'b1101,
        G_NOT   = 4'b1110,
        G_NOT2  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        ZERO = 2'b11
    } sh_op_e;

    localparam int TAG_V = 3;
    localparam int TAG_C = 2;
    localparam int TAG_N = 1;
    localparam int TAG_Z = 0;

endpackage

// File: rtl/procesador_func_unit.sv
// Function unit: ALU with {V,C,N,Z} flags, a one-bit shifter on bus B, and the
// ALU/shifter select. Purely combinational.
module procesador_func_unit
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic [3:0]   g_sel,
    input  logic [1:0]   h_sel,
    input  logic         mf_sel,
    output logic [m-1:0] f,
    output logic [3:0]   tags
);

    alu_op_e      op;
    sh_op_e       hop;
    logic [m-1:0] opb;
    logic         cin;
    logic         arith;
    logic [m-1:0] logic_res;
    logic [m:0]   sum;
    logic [m-1:0] alu_res;
    logic [m-1:0] sh_res;

    assign op  = alu_op_e'(g_sel);
    assign hop = sh_op_e'(h_sel);

    // Arithmetic codes share one adder: pick the second operand and carry-in.
    always_comb begin
        opb       = '0;
        cin       = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (op)
            G_INC:          cin = 1'b1;
            G_ADD:          opb = b;
            G_ADDC:         begin opb = b;  cin = 1'b1; end
            G_ADDNB:        opb = ~b;
            G_SUB:          begin opb = ~b; cin = 1'b1; end
            G_DEC:          opb = '1;
            G_AND, G_AND2:  begin arith = 1'b0; logic_res = a & b; end
            G_OR, G_OR2:    begin arith = 1'b0; logic_res = a | b; end
            G_XOR, G_XOR2:  begin arith = 1'b0; logic_res = a ^ b; end
            G_NOT, G_NOT2:  begin arith = 1'b0; logic_res = ~a; end
            default:        ;
        endcase
    end

    assign sum     = {1'b0, a} + {1'b0, opb} + {{m{1'b0}}, cin};
    assign alu_res = arith ? sum[m-1:0] : logic_res;

    always_comb begin
        tags        = '0;
        tags[TAG_C] = arith & sum[m];
        tags[TAG_V] = arith & (a[m-1] == opb[m-1]) & (sum[m-1] != a[m-1]);
        tags[TAG_N] = alu_res[m-1];
        tags[TAG_Z] = (alu_res == '0);
    end

    always_comb begin
        sh_res = '0;
        case (hop)
            PASS:    sh_res = b;
            SHL:     sh_res = {b[m-2:0], 1'b0};
            SHR:     sh_res = {1'b0, b[m-1:1]};
            default: sh_res = '0;
        endcase
    end

    assign f = mf_sel ? sh_res : alu_res;

endmodule

// File: rtl/procesador.sv
// Single-cycle execution datapath: 4-entry register file, bus B/D muxes and the
// function unit. All selects come from an external control unit each cycle.
module procesador
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   A_sel,
    input  logic [1:0]   B_sel,
    input  logic [1:0]   Dest_sel,
    input  logic         Load_en,
    input  logic         MB_sel,
    input  logic [m-1:0] Cons_IN,
    input  logic [3:0]   G_sel,
    input  logic [1:0]   H_sel,
    input  logic         MF_sel,
    input  logic         MD_sel,
    input  logic [m-1:0] Data_IN,
    output logic [m-1:0] Address_out,
    output logic [m-1:0] Data_out,
    output logic [3:0]   Tags,
    output logic [m-1:0] Reg_in
);

    logic [3:0][m-1:0] rf;
    logic [m-1:0]      a_bus;
    logic [m-1:0]      b_bus;
    logic [m-1:0]      f_bus;
    logic [m-1:0]      d_bus;

    // Clear is immediate on rst_n low and wins over any write; no read bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rf <= '0;
        else if (Load_en)
            rf[Dest_sel] <= d_bus;
    end

    assign a_bus = rf[A_sel];
    assign b_bus = MB_sel ? Cons_IN : rf[B_sel];

    procesador_func_unit #(.m(m)) u_fu (
        .a      (a_bus),
        .b      (b_bus),
        .g_sel  (G_sel),
        .h_sel  (H_sel),
        .mf_sel (MF_sel),
        .f      (f_bus),
        .tags   (Tags)
    );

    assign d_bus       = MD_sel ? Data_IN : f_bus;
    assign Reg_in      = d_bus;
    assign Address_out = a_bus;
    assign Data_out    = b_bus;

endmodule

// File: tb/tb_procesador.sv
// Directed self-checking bench for procesador (m=8) with hand-computed expectations.
module tb_procesador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] A_sel, B_sel, Dest_sel, H_sel;
    logic       Load_en, MB_sel, MF_sel, MD_sel;
    logic [7:0] Cons_IN, Data_IN;
    logic [3:0] G_sel;
    logic [7:0] Address_out, Data_out, Reg_in;
    logic [3:0] Tags;

    int checks   = 0;
    int failures = 0;

    procesador #(.m(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A_sel       (A_sel),
        .B_sel       (B_sel),
        .Dest_sel    (Dest_sel),
        .Load_en     (Load_en),
        .MB_sel      (MB_sel),
        .Cons_IN     (Cons_IN),
        .G_sel       (G_sel),
        .H_sel       (H_sel),
        .MF_sel      (MF_sel),
        .MD_sel      (MD_sel),
        .Data_IN     (Data_IN),
        .Address_out (Address_out),
        .Data_out    (Data_out),
        .Tags        (Tags),
        .Reg_in      (Reg_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] dst, input logic [7:0] val);
        Dest_sel = dst; Data_IN = val; MD_sel = 1'b1; Load_en = 1'b1;
        tick();
        Load_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        A_sel = idx;
        #1;
        chk(tag, Address_out, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        A_sel = 0; B_sel = 0; Dest_sel = 0; H_sel = 0;
        Load_en = 0; MB_sel = 0; MF_sel = 0; MD_sel = 0;
        Cons_IN = 0; Data_IN = 0; G_sel = 0;
        #2;
        chk("rst_addr", Address_out, 8'h00);
        chk("rst_data_reg", Data_out, 8'h00);
        MB_sel = 1'b1; Cons_IN = 8'h5A; #1;
        chk("rst_data_cons", Data_out, 8'h5A);
        MB_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Load via Data_IN
        Dest_sel = 1; Data_IN = 8'h04; MD_sel = 1; #1;
        chk("regin_datain", Reg_in, 8'h04);
        load(2'd1, 8'd4);
        load(2'd2, 8'd8);
        load(2'd3, 8'd12);
        MD_sel = 0;
        A_sel = 1; B_sel = 2; MB_sel = 0; #1;
        chk("addr_r1", Address_out, 8'd4);
        chk("data_r2", Data_out, 8'd8);

        // A+B and shift-left of B
        G_sel = 4'b0010; MF_sel = 0; #1;
        chk("add_res", Reg_in, 8'd12);
        chk("add_tags", {4'h0, Tags}, 8'h00);
        MF_sel = 1; H_sel = 2'b01; #1;
        chk("shl_res", Reg_in, 8'd16);

        // Subtract family with A=R2=8, B=R1=4
        MF_sel = 0; A_sel = 2; B_sel = 1;
        G_sel = 4'b0100; #1;
        chk("addnb_res", Reg_in, 8'd3);
        chk("addnb_tags", {4'h0, Tags}, 8'h04);
        G_sel = 4'b0101; #1;
        chk("sub_res", Reg_in, 8'd4);
        chk("sub_tags", {4'h0, Tags}, 8'h04);
        G_sel = 4'b0110; #1;
        chk("dec_res", Reg_in, 8'd7);
        chk("dec_tags", {4'h0, Tags}, 8'h04);
        G_sel = 4'b0001; #1;
        chk("inc_res", Reg_in, 8'd9);
        G_sel = 4'b0011; #1;
        chk("addc_res", Reg_in, 8'd13);

        // Logic ops, A=R3=0x0C, B=R2=0x08
        A_sel = 3; B_sel = 2;
        G_sel = 4'b1000; #1; chk("and_res", Reg_in, 8'h08);
        G_sel = 4'b1011; #1; chk("or_res",  Reg_in, 8'h0C);
        G_sel = 4'b1101; #1; chk("xor_res", Reg_in, 8'h04);
        G_sel = 4'b1110; #1;
        chk("not_res", Reg_in, 8'hF3);
        chk("not_tags", {4'h0, Tags}, 8'h02);

        // Shifter on constant bus B
        MB_sel = 1; Cons_IN = 8'd16; MF_sel = 1; H_sel = 2'b11; #1;
        chk("zero_res", Reg_in, 8'd0);
        chk("zero_dout", Data_out, 8'd16);
        H_sel = 2'b10; #1;
        chk("shr_res", Reg_in, 8'd8);
        H_sel = 2'b00; #1;
        chk("pass_res", Reg_in, 8'd16);

        // Overflow and zero
        load(2'd1, 8'h7F);
        MD_sel = 0; MF_sel = 0; A_sel = 1; MB_sel = 1; Cons_IN = 8'd1; G_sel = 4'b0010; #1;
        chk("ovf_res", Reg_in, 8'h80);
        chk("ovf_tags", {4'h0, Tags}, 8'h0A);
        MB_sel = 0; B_sel = 1; G_sel = 4'b0101; #1;
        chk("zero_sub_res", Reg_in, 8'h00);
        chk("zero_sub_tags", {4'h0, Tags}, 8'h05);

        // Writeback through ALU; old value visible until the edge
        A_sel = 3; B_sel = 2; G_sel = 4'b0010; MB_sel = 0; MD_sel = 0;
        Dest_sel = 3; Load_en = 1; #1;
        chk("nobypass", Address_out, 8'd12);
        tick();
        Load_en = 0;
        read_reg(2'd3, 8'd20, "wb_r3");

        // Load_en=0 holds state
        MD_sel = 1; Data_IN = 8'hEE; Dest_sel = 2;
        tick(); tick(); tick();
        read_reg(2'd0, 8'h00, "hold_r0");
        read_reg(2'd1, 8'h7F, "hold_r1");
        read_reg(2'd2, 8'h08, "hold_r2");
        read_reg(2'd3, 8'd20, "hold_r3");

        // Async reset mid-cycle with Load_en asserted
        Load_en = 1; Dest_sel = 2; A_sel = 3; B_sel = 1; #2;
        rst_n = 1'b0; #1;
        chk("arst_addr", Address_out, 8'h00);
        chk("arst_data", Data_out, 8'h00);
        tick();
        chk("arst_hold", Data_out, 8'h00);
        Load_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        load(2'd2, 8'h33);
        read_reg(2'd2, 8'h33, "post_rst_wr");
        read_reg(2'd1, 8'h00, "post_rst_r1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
